data_memory_responder: RTL and testbench

- Responder end of the core's data-memory interface. It owns the word-addressed data RAM and a small memory-mapped I/O (MMIO) register bank: GPIO output, free-running cycle counter, timer compare and status.
- A secondary host/debug port (4-phase req/ack) gives a test host read and write access to the same address map. Core accesses always have priority over host accesses.
- Sits beside the pipelined data path; core reads are combinational so the MEM/WB register captures read data in the same cycle.

---
 rtl/data_memory_responder.sv | 164 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`timescale 1ns/1ps
// Data-memory responder: word-addressed RAM plus a small MMIO bank (GPIO,
// free-running cycle counter, timer compare, sticky match status), with a
// 4-phase host/debug port that yields to core writes.
module data_memory_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int GPIO_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      ram_address,
    input  logic [WIDTH-1:0]      ram_w_data,
    input  logic                  read_write_ram_en,
    output logic [WIDTH-1:0]      ram_r_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [WIDTH-1:0]      host_addr,
    input  logic [WIDTH-1:0]      host_wdata,
    output logic [WIDTH-1:0]      host_rdata,
    output logic                  host_ack,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } host_state_t;

    logic [WIDTH-1:0]      mem [WORDS];
    logic [GPIO_WIDTH-1:0] gpio_reg;
    logic [WIDTH-1:0]      cycle_reg;
    logic [WIDTH-1:0]      cmp_reg;
    logic                  status_reg;

    host_state_t           state;
    host_state_t           next_state;
    logic                  host_commit;
    logic                  host_capture;

    logic                  wr_en;
    logic [WIDTH-1:0]      wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  mmio_wr;
    logic [1:0]            mmio_sel;
    logic                  status_clear;
    logic                  match;
    logic [WIDTH-1:0]      host_decode;
    logic                  unused_addr_bits;

    // MMIO read mux; only addr[3:2] participate in the decode.
    function automatic logic [WIDTH-1:0] mmio_read(input logic [1:0] sel);
        logic [WIDTH-1:0] value;
        value = '0;
        case (sel)
            2'd0:    value = {{(WIDTH-GPIO_WIDTH){1'b0}}, gpio_reg};
            2'd1:    value = cycle_reg;
            2'd2:    value = cmp_reg;
            default: value = {{(WIDTH-1){1'b0}}, status_reg};
        endcase
        return value;
    endfunction

    // Core and host share one decode; the core read has no latency.
    assign ram_r_data  = ram_address[WIDTH-1] ? mmio_read(ram_address[3:2])
                                              : mem[ram_address[DEPTH_LOG2+1:2]];
    assign host_decode = host_addr[WIDTH-1] ? mmio_read(host_addr[3:2])
                                            : mem[host_addr[DEPTH_LOG2+1:2]];

    // A single write port: the host only commits when the core is not writing.
    assign wr_en   = read_write_ram_en | host_commit;
    assign wr_addr = read_write_ram_en ? ram_address : host_addr;
    assign wr_data = read_write_ram_en ? ram_w_data  : host_wdata;

    assign mmio_wr      = wr_en & wr_addr[WIDTH-1];
    assign mmio_sel     = wr_addr[3:2];
    assign status_clear = mmio_wr & (mmio_sel == 2'd3) & wr_data[0];
    assign match        = (cycle_reg == cmp_reg);

    // Alias bits and byte offset do not take part in the decode.
    assign unused_addr_bits = ^{wr_addr[WIDTH-2:DEPTH_LOG2+2], wr_addr[1:0]};

    assign gpio_out  = gpio_reg;
    assign timer_irq = status_reg;
    assign host_ack  = (state == ACK);

    // RAM write; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en && !wr_addr[WIDTH-1]) begin
            mem[wr_addr[DEPTH_LOG2+1:2]] <= wr_data;
        end
    end

    // MMIO registers: a CYCLE write overrides the increment, and a match set beats a clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpio_reg   <= '0;
            cycle_reg  <= '0;
            cmp_reg    <= '1;
            status_reg <= 1'b0;
        end else begin
            cycle_reg  <= cycle_reg + WIDTH'(1);
            status_reg <= match | (status_reg & ~status_clear);
            if (mmio_wr) begin
                case (mmio_sel)
                    2'd0:    gpio_reg  <= wr_data[GPIO_WIDTH-1:0];
                    2'd1:    cycle_reg <= wr_data;
                    2'd2:    cmp_reg   <= wr_data;
                    default: ;
                endcase
            end
        end
    end

    // Host handshake state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Host next-state logic; the access is held off while the core writes.
    always_comb begin
        next_state   = state;
        host_commit  = 1'b0;
        host_capture = 1'b0;
        case (state)
            IDLE: begin
                if (host_req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (!read_write_ram_en) begin
                    host_commit  = host_we;
                    host_capture = ~host_we;
                    next_state   = ACK;
                end
            end
            ACK: begin
                if (!host_req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Host read data is captured at the edge that completes the access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            host_rdata <= '0;
        end else if (host_capture) begin
            host_rdata <= host_decode;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
`timescale 1ns/1ps
// Self-checking bench for data_memory_responder with a word-level memory model.
module tb_data_memory_responder;

    logic        clock;
    logic        reset;
    logic [31:0] ram_address;
    logic [31:0] ram_w_data;
    logic        read_write_ram_en;
    logic [31:0] ram_r_data;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int errors;
    int checks;

    // Reference RAM keyed by word index (addr[11:2]).
    logic [31:0] ref_ram [int];

    data_memory_responder #(.WIDTH(32), .DEPTH_LOG2(10), .GPIO_WIDTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .ram_address(ram_address),
        .ram_w_data(ram_w_data),
        .read_write_ram_en(read_write_ram_en),
        .ram_r_data(ram_r_data),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .host_ack(host_ack),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic core_write(input logic [31:0] a, input logic [31:0] d);
        ram_address       = a;
        ram_w_data        = d;
        read_write_ram_en = 1'b1;
        tick();
        read_write_ram_en = 1'b0;
        if (!a[31]) ref_ram[int'(a[11:2])] = d;
    endtask

    // Raises req and waits (bounded) for ack; req is left high.
    task automatic host_start(input logic we, input logic [31:0] a, input logic [31:0] d,
                              output int edges);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        edges      = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (host_ack) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ram_address = 32'h0; ram_w_data = 32'h0; read_write_ram_en = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
        tick(); tick();
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio got=%h exp=00", gpio_out); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", host_ack); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", host_rdata); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
        ram_address = 32'h8000_0008; #1;
        checks++; if (ram_r_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp got=%h exp=ffffffff", ram_r_data); end
        ram_address = 32'h8000_0004; #1;
        checks++; if (ram_r_data !== 32'h0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", ram_r_data); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_ram_rw();
        logic [31:0] a;
        int idx;
        core_write(32'h0000_0010, 32'hDEAD_BEEF);
        ram_address = 32'h0000_0010; #1;
        checks++; if (ram_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_10 got=%h exp=deadbeef", ram_r_data); end
        ram_address = 32'h0000_0013; #1;
        checks++; if (ram_r_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_13 got=%h exp=deadbeef", ram_r_data); end
        // Random traffic on a small window, with random alias bits and byte offsets.
        for (int i = 0; i < 60; i++) begin
            idx = int'($urandom_range(0, 23));
            a = {1'b0, 19'($urandom), 10'(idx), 2'($urandom)};
            if ($urandom_range(0, 1) == 0 || !ref_ram.exists(idx)) begin
                core_write(a, $urandom);
            end else begin
                ram_address = a; #1;
                checks++;
                if (ram_r_data !== ref_ram[idx]) begin
                    errors++;
                    $display("FAIL ram_random addr=%h got=%h exp=%h", a, ram_r_data, ref_ram[idx]);
                end
            end
        end
    endtask

    task automatic test_gpio();
        logic [31:0] v;
        core_write(32'h8000_0000, 32'h0000_01A5);
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL gpio_out got=%h exp=a5", gpio_out); end
        ram_address = 32'h8000_0000; #1;
        checks++; if (ram_r_data !== 32'h0000_00A5) begin errors++; $display("FAIL gpio_read got=%h exp=000000a5", ram_r_data); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            core_write({1'b1, 27'($urandom), 2'b00, 2'($urandom)}, v);
            ram_address = 32'h8000_0000; #1;
            checks++;
            if (ram_r_data !== {24'h0, v[7:0]}) begin
                errors++;
                $display("FAIL gpio_alias got=%h exp=%h", ram_r_data, {24'h0, v[7:0]});
            end
        end
    endtask

    task automatic test_timer();
        core_write(32'h8000_0004, 32'd10);
        core_write(32'h8000_0008, 32'd20);
        ram_address = 32'h8000_0004; #1;
        checks++; if (ram_r_data !== 32'd11) begin errors++; $display("FAIL cycle_count got=%0d exp=11", ram_r_data); end
        // Edge k after the CYCLE write: the match at CYCLE=20 shows at edge 11.
        for (int k = 2; k <= 11; k++) begin
            tick();
            checks++;
            if (timer_irq !== (k == 11)) begin
                errors++;
                $display("FAIL irq_edge k=%0d got=%b exp=%b", k, timer_irq, (k == 11));
            end
        end
        core_write(32'h8000_000C, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
        ram_address = 32'h8000_000C; #1;
        checks++; if (ram_r_data !== 32'h0) begin errors++; $display("FAIL status_read got=%h exp=0", ram_r_data); end
        core_write(32'h8000_0004, 32'hFFFF_FFFF);
        ram_address = 32'h8000_0004; #1;
        checks++; if (ram_r_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_load got=%h exp=ffffffff", ram_r_data); end
        tick();
        checks++; if (ram_r_data !== 32'h0) begin errors++; $display("FAIL cycle_wrap got=%h exp=0", ram_r_data); end
        // Set and clear on the same edge: set wins.
        core_write(32'h8000_0008, 32'd50);
        core_write(32'h8000_0004, 32'd50);
        core_write(32'h8000_000C, 32'h1);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", timer_irq); end
        core_write(32'h8000_000C, 32'h1);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL clear_after got=%b exp=0", timer_irq); end
    endtask

    task automatic test_host();
        int edges;
        logic [31:0] a;
        logic [31:0] d;
        int idx;
        host_start(1'b1, 32'h0000_0040, 32'h1234_5678, edges);
        ref_ram[16] = 32'h1234_5678;
        checks++; if (edges !== 2) begin errors++; $display("FAIL host_wr_latency got=%0d exp=2", edges); end
        host_req = 1'b0; tick();
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL host_ack_drop got=%b exp=0", host_ack); end
        host_start(1'b0, 32'h0000_0040, 32'h0, edges);
        checks++; if (edges !== 2) begin errors++; $display("FAIL host_rd_latency got=%0d exp=2", edges); end
        checks++; if (host_rdata !== 32'h1234_5678) begin errors++; $display("FAIL host_rd_data got=%h exp=12345678", host_rdata); end
        host_req = 1'b0; tick();
        // Host write to GPIO.
        host_start(1'b1, 32'h8000_0000, 32'h0000_005A, edges);
        checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL host_gpio got=%h exp=5a", gpio_out); end
        host_req = 1'b0; tick();
        // Random host traffic, with core reads running alongside.
        for (int i = 0; i < 20; i++) begin
            idx = int'($urandom_range(0, 23));
            a = {1'b0, 19'($urandom), 10'(idx), 2'($urandom)};
            ram_address = {20'h0, 10'($urandom_range(0, 23)), 2'b00};
            if ($urandom_range(0, 1) == 0 || !ref_ram.exists(idx)) begin
                d = $urandom;
                host_start(1'b1, a, d, edges);
                ref_ram[idx] = d;
            end else begin
                host_start(1'b0, a, 32'h0, edges);
                checks++;
                if (host_rdata !== ref_ram[idx]) begin
                    errors++;
                    $display("FAIL host_random addr=%h got=%h exp=%h", a, host_rdata, ref_ram[idx]);
                end
            end
            checks++;
            if (edges !== 2) begin errors++; $display("FAIL host_random_latency got=%0d exp=2", edges); end
            host_req = 1'b0; tick();
        end
    endtask

    task automatic test_back_to_back_stall();
        int edges;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0000_0100; host_wdata = 32'hCAFE_0001;
        tick();
        edges = 1;
        for (int i = 0; i < 3; i++) begin
            ram_address = 32'h0000_0180 + 32'(4 * i);
            ram_w_data  = 32'hB0B0_0000 + 32'(i);
            read_write_ram_en = 1'b1;
            ref_ram[int'(ram_address[11:2])] = ram_w_data;
            tick();
            edges++;
            checks++;
            if (host_ack !== 1'b0) begin errors++; $display("FAIL stall_ack i=%0d got=%b exp=0", i, host_ack); end
        end
        read_write_ram_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (host_ack) break;
        end
        ref_ram[64] = 32'hCAFE_0001;
        checks++; if (edges !== 5) begin errors++; $display("FAIL stall_latency got=%0d exp=5", edges); end
        host_req = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            ram_address = 32'h0000_0180 + 32'(4 * i); #1;
            checks++;
            if (ram_r_data !== 32'hB0B0_0000 + 32'(i)) begin
                errors++;
                $display("FAIL stall_core_data i=%0d got=%h exp=%h", i, ram_r_data, 32'hB0B0_0000 + 32'(i));
            end
        end
        ram_address = 32'h0000_0100; #1;
        checks++; if (ram_r_data !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_host_data got=%h exp=cafe0001", ram_r_data); end
    endtask

    task automatic test_reset_mid_handshake();
        int edges;
        core_write(32'h8000_0008, 32'd5);
        core_write(32'h8000_0000, 32'h3C);
        host_start(1'b1, 32'h0000_0200, 32'h1111_2222, edges);
        ref_ram[128] = 32'h1111_2222;
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL pre_reset_ack got=%b exp=1", host_ack); end
        #3 reset = 1'b1;
        #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL async_ack got=%b exp=0", host_ack); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL async_gpio got=%h exp=00", gpio_out); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL async_irq got=%b exp=0", timer_irq); end
        ram_address = 32'h8000_0004; #1;
        checks++; if (ram_r_data !== 32'h0) begin errors++; $display("FAIL async_cycle got=%h exp=0", ram_r_data); end
        ram_address = 32'h8000_0008; #1;
        checks++; if (ram_r_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL async_cmp got=%h exp=ffffffff", ram_r_data); end
        // Release with req still high: a fresh access runs to completion.
        host_addr = 32'h0000_0204; host_wdata = 32'h3333_4444;
        tick();
        reset = 1'b0;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (host_ack) break;
        end
        ref_ram[129] = 32'h3333_4444;
        checks++; if (edges !== 2) begin errors++; $display("FAIL fresh_access_latency got=%0d exp=2", edges); end
        host_req = 1'b0; tick();
        ram_address = 32'h0000_0204; #1;
        checks++; if (ram_r_data !== 32'h3333_4444) begin errors++; $display("FAIL fresh_access_data got=%h exp=33334444", ram_r_data); end
        // A stalled host write cut short by reset never lands.
        core_write(32'h0000_0300, 32'h0DD0_0DD0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0000_0300; host_wdata = 32'hBADB_AD00;
        ram_address = 32'h0000_0304; ram_w_data = 32'h7777_0000; read_write_ram_en = 1'b1;
        ref_ram[193] = 32'h7777_0000;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        host_req = 1'b0; read_write_ram_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        ram_address = 32'h0000_0300; #1;
        checks++; if (ram_r_data !== 32'h0DD0_0DD0) begin errors++; $display("FAIL discard_host_wr got=%h exp=0dd00dd0", ram_r_data); end
        ram_address = 32'h0000_0304; #1;
        checks++; if (ram_r_data !== 32'h7777_0000) begin errors++; $display("FAIL core_wr_kept got=%h exp=77770000", ram_r_data); end
        ram_address = 32'h0000_0010; #1;
        checks++; if (ram_r_data !== ref_ram[4]) begin errors++; $display("FAIL ram_kept got=%h exp=%h", ram_r_data, ref_ram[4]); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_ram_rw();
        test_gpio();
        test_timer();
        test_host();
        test_back_to_back_stall();
        test_reset_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
